// File: rtl/fractal_pkg.sv
// fractal_pkg: shared types and helpers for the fractal engine result path.
//   ITER_W        default iteration-count width
//   iter_entry_t  one pixel result {iter, in_set}
//   lvl_w()       width needed to hold an occupancy of 0..depth
package fractal_pkg;
    localparam int ITER_W = 6;
    typedef struct packed {
        logic [ITER_W-1:0] iter;
        logic              in_set;
    } iter_entry_t;
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/iter_fifo_mem.sv
// iter_fifo_mem: DEPTH x W storage array, one synchronous write port, one async read port, no reset.
//   clk          clock
//   we/waddr/wdata  write port
//   raddr/rdata     combinational read port
module iter_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 7
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/iter_fifo.sv
// iter_fifo: show-ahead FIFO of pixel results between the fractal engine and its consumer.
//   clk, rst_n (async active-low), flush (frame start, empties FIFO)
//   write side: wr_valid, wr_ready, wr_iter, wr_in_set
//   read side:  rd_req, rd_valid, rd_iter, rd_in_set
//   status:     level (occupancy), underflow (sticky read-while-empty)
//   ITER_FIFO_STATS_EN: adds underflow_cnt, a saturating 8-bit count of underflow events
module iter_fifo
    import fractal_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ITER_WIDTH = ITER_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ITER_WIDTH-1:0]    wr_iter,
    input  logic                     wr_in_set,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [ITER_WIDTH-1:0]    rd_iter,
    output logic                     rd_in_set,
    output logic [lvl_w(DEPTH)-1:0]  level,
    output logic                     underflow
`ifdef ITER_FIFO_STATS_EN
    ,
    output logic [7:0]               underflow_cnt
`endif
);
    localparam int LW = lvl_w(DEPTH);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = ITER_WIDTH + 1;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head, hold;
    logic          wr_en, rd_en, uf_evt;
    assign wr_ready = level != LW'(DEPTH);
    assign rd_valid = level != '0;
    // flush discards any write or read presented in the same cycle
    assign wr_en  = wr_valid && wr_ready && !flush;
    assign rd_en  = rd_req && rd_valid && !flush;
    assign uf_evt = rd_req && !rd_valid && !flush;
    // when empty, show the last popped entry so stale storage never leaks out
    assign {rd_iter, rd_in_set} = rd_valid ? head : hold;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    iter_fifo_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({wr_iter, wr_in_set}),
        .raddr (rd_ptr),
        .rdata (head)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            hold      <= '0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= inc(wr_ptr);
            if (rd_en) begin
                rd_ptr <= inc(rd_ptr);
                hold   <= head;
            end
            level <= level + LW'(wr_en) - LW'(rd_en);
            if (uf_evt) underflow <= 1'b1;
        end
    end
`ifdef ITER_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) underflow_cnt <= '0;
        else if (uf_evt && underflow_cnt != 8'hff) underflow_cnt <= underflow_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_iter_fifo.sv
// tb_iter_fifo: directed and randomized checks of iter_fifo against a queue-based model.
module tb_iter_fifo;
    import fractal_pkg::*;
    localparam int DEPTH = 8;
    localparam int IW    = 6;
    logic          clk = 0, rst_n = 0, flush = 0, wr_valid = 0, wr_in_set = 0, rd_req = 0;
    logic [IW-1:0] wr_iter = '0, rd_iter;
    logic          wr_ready, rd_valid, rd_in_set, underflow;
    logic [3:0]    level;
`ifdef ITER_FIFO_STATS_EN
    logic [7:0]    underflow_cnt;
`endif
    int errs = 0, checks = 0;
    iter_entry_t q[$];
    iter_entry_t m_last, e;
    bit          m_uf, m_rv, m_wr;
    int          m_cnt;

    iter_fifo #(.DEPTH(DEPTH), .ITER_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_iter(wr_iter), .wr_in_set(wr_in_set),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_iter(rd_iter), .rd_in_set(rd_in_set),
        .level(level), .underflow(underflow)
`ifdef ITER_FIFO_STATS_EN
        , .underflow_cnt(underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: FIFO as a queue, updated from the inputs seen at each edge
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete(); m_uf = 0; m_last = '0; m_cnt = 0;
        end else if (flush) begin
            q.delete(); m_uf = 0;
        end else begin
            m_rv = q.size() != 0;
            m_wr = wr_valid && q.size() != DEPTH;
            if (rd_req && m_rv) m_last = q.pop_front();
            if (rd_req && !m_rv) begin
                m_uf = 1;
                if (m_cnt != 255) m_cnt++;
            end
            if (m_wr) begin
                e.iter = wr_iter; e.in_set = wr_in_set;
                q.push_back(e);
            end
        end
    end

    // compare every cycle, on the falling edge
    initial forever begin
        @(negedge clk);
        e = q.size() != 0 ? q[0] : m_last;
        chk("level", int'(level), q.size());
        chk("wr_ready", int'(wr_ready), int'(q.size() != DEPTH));
        chk("rd_valid", int'(rd_valid), int'(q.size() != 0));
        chk("rd_iter", int'(rd_iter), int'(e.iter));
        chk("rd_in_set", int'(rd_in_set), int'(e.in_set));
        chk("underflow", int'(underflow), int'(m_uf));
`ifdef ITER_FIFO_STATS_EN
        chk("underflow_cnt", int'(underflow_cnt), m_cnt);
`endif
    end

    task automatic step(input bit wv, input int it, input bit is, input bit rr, input bit fl);
        wr_valid = wv; wr_iter = IW'(it); wr_in_set = is; rd_req = rr; flush = fl;
        @(posedge clk); #1;
        wr_valid = 0; rd_req = 0; flush = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst level", int'(level), 0);
        chk("rst wr_ready", int'(wr_ready), 1);
        chk("rst rd_valid", int'(rd_valid), 0);
        chk("rst rd_iter", int'(rd_iter), 0);
        chk("rst underflow", int'(underflow), 0);
        rst_n = 1;
        // single push visible next cycle
        step(1, 5, 0, 0, 0);
        chk("push1 rd_valid", int'(rd_valid), 1);
        chk("push1 rd_iter", int'(rd_iter), 5);
        chk("push1 level", int'(level), 1);
        step(0, 0, 0, 0, 1);
        // fill, overfill, drain in order
        for (int i = 1; i <= 8; i++) step(1, i, i[0], 0, 0);
        chk("full wr_ready", int'(wr_ready), 0);
        chk("full level", int'(level), 8);
        step(1, 9, 0, 0, 0);
        chk("9th ignored level", int'(level), 8);
        for (int i = 1; i <= 8; i++) begin
            chk("drain order", int'(rd_iter), i);
            step(0, 0, 0, 1, 0);
        end
        chk("drained rd_valid", int'(rd_valid), 0);
        chk("empty hold", int'(rd_iter), 8);
        // full with simultaneous read and write
        for (int i = 1; i <= 8; i++) step(1, i, 0, 0, 0);
        chk("full head", int'(rd_iter), 1);
        step(1, 9, 0, 1, 0);
        chk("full rw level", int'(level), 7);
        chk("full rw wr_ready", int'(wr_ready), 1);
        chk("full rw head", int'(rd_iter), 2);
        step(0, 0, 0, 0, 1);
        // empty with simultaneous read and write
        step(1, 63, 1, 1, 0);
        chk("uf flag", int'(underflow), 1);
        chk("uf level", int'(level), 1);
        chk("uf rd_iter", int'(rd_iter), 63);
`ifdef ITER_FIFO_STATS_EN
        chk("uf cnt", int'(underflow_cnt), 1);
`endif
        // flush at level 4 with concurrent traffic
        for (int i = 0; i < 3; i++) step(1, 20 + i, 0, 0, 0);
        chk("pre-flush level", int'(level), 4);
        step(1, 30, 0, 1, 1);
        chk("flush level", int'(level), 0);
        chk("flush rd_valid", int'(rd_valid), 0);
        chk("flush underflow", int'(underflow), 0);
        // streaming across pointer wrap
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            chk("stream head", int'(rd_iter), i - 1);
            step(1, i, 0, 1, 0);
            chk("stream level", int'(level), 1);
        end
        // randomized traffic with a reset in the middle
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) begin
                #2 rst_n = 0;
                #1;
                chk("midrst level", int'(level), 0);
                chk("midrst rd_valid", int'(rd_valid), 0);
                chk("midrst rd_iter", int'(rd_iter), 0);
                @(posedge clk); #1 rst_n = 1;
            end
            step($urandom_range(0, 9) < 6, $urandom_range(0, 63), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 49) == 0);
        end
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
